// File: rtl/io_out_arbiter_pkg.sv
// Shared types and default parameters for the user-output byte arbiter.
// Holds the FSM state encoding and a helper for grant-index widths.
package io_out_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_IDLE = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int DEF_NREQ        = 2;
   localparam int DEF_HOLD_CYCLES = 4;
   localparam int DEF_BOOT_DELAY  = 16;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/io_out_arbiter_if.sv
// Requester handshake plus user-pin outputs of the output-byte arbiter.
// The slave modport is the arbiter side; master is the requester/pin side.
interface io_out_arbiter_if import io_out_arbiter_pkg::*; #(
   parameter int NREQ = DEF_NREQ
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        io_out;
   logic [7:0]        io_oeb;
   logic              io_ready;
   logic              busy;

   modport slave (
      input  req_valid, req_data,
      output req_ready, io_out, io_oeb, io_ready, busy
   );

   modport master (
      output req_valid, req_data,
      input  req_ready, io_out, io_oeb, io_ready, busy
   );
endinterface

// File: rtl/io_out_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: first set request found searching upward
// from the slot after the last grant, wrapping modulo NREQ.
module rr_arbiter import io_out_arbiter_pkg::*; #(
   parameter  int NREQ = DEF_NREQ,
   localparam int IDXW = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDXW-1:0] last_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDXW-1:0] gnt_idx_o
);
   logic [NREQ-1:0] gnt_s;
   logic [IDXW-1:0] gnt_idx_s;
   logic            found_s;
   int              cand_s;

   // priority search starting one past the previous winner
   always_comb begin
      gnt_s     = '0;
      gnt_idx_s = '0;
      found_s   = 1'b0;
      cand_s    = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_s = (int'(last_i) + k) % NREQ;
         if (!found_s && req_i[cand_s]) begin
            gnt_s[cand_s] = 1'b1;
            gnt_idx_s     = IDXW'(cand_s);
            found_s       = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign gnt_o     = gnt_s;
   assign gnt_idx_o = gnt_idx_s;
endmodule

// File: rtl/io_out_arbiter.sv
// Shares the user output byte among NREQ requesters: boot delay, then
// round-robin grants, each accepted byte held for HOLD_CYCLES cycles.
module io_out_arbiter import io_out_arbiter_pkg::*; #(
   parameter int NREQ        = DEF_NREQ,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int BOOT_DELAY  = DEF_BOOT_DELAY
) (
   input logic        clk,
   input logic        rst_l,
   io_out_arbiter_if.slave bus
);
   localparam int         IDXW      = idx_width(NREQ);
   localparam logic [15:0] BOOT_LAST = 16'(BOOT_DELAY - 1);
   localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

   state_e            state_q, state_d;
   logic [15:0]       boot_cnt_q, boot_cnt_d;
   logic [7:0]        hold_cnt_q, hold_cnt_d;
   logic [7:0]        io_out_q, io_out_d;
   logic [7:0]        io_oeb_q, io_oeb_d;
   logic              io_ready_q, io_ready_d;
   logic              busy_q, busy_d;
   logic [IDXW-1:0]   last_grant_q, last_grant_d;
   logic [NREQ-1:0]   gnt_s;
   logic [IDXW-1:0]   gnt_idx_s;
   logic [NREQ-1:0]   req_ready_s;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req_i     (bus.req_valid),
      .last_i    (last_grant_q),
      .gnt_o     (gnt_s),
      .gnt_idx_o (gnt_idx_s)
   );

   // next-state, counters, captured byte and registered pin controls
   always_comb begin
      state_d      = state_q;
      boot_cnt_d   = boot_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      io_out_d     = io_out_q;
      last_grant_d = last_grant_q;
      req_ready_s  = '0;
      case (state_q)
         ST_BOOT: begin
            if (boot_cnt_q >= BOOT_LAST) begin
               state_d = ST_IDLE;
            end else begin
               boot_cnt_d = boot_cnt_q + 16'd1;
            end
         end
         ST_IDLE: begin
            req_ready_s = gnt_s;
            if (|gnt_s) begin
               io_out_d     = bus.req_data[8*gnt_idx_s +: 8];
               last_grant_d = gnt_idx_s;
               hold_cnt_d   = HOLD_LOAD;
               state_d      = ST_HOLD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            // the counter stops at zero; the exit happens on the zero cycle
            if (hold_cnt_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
      io_ready_d = (state_d != ST_BOOT);
      io_oeb_d   = io_ready_d ? 8'h00 : 8'hFF;
      busy_d     = (state_d == ST_HOLD);
   end

   // state and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q      <= ST_BOOT;
         boot_cnt_q   <= 16'd0;
         hold_cnt_q   <= 8'd0;
         io_out_q     <= 8'h00;
         io_oeb_q     <= 8'hFF;
         io_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         last_grant_q <= LAST_RST;
      end else begin
         state_q      <= state_d;
         boot_cnt_q   <= boot_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         io_out_q     <= io_out_d;
         io_oeb_q     <= io_oeb_d;
         io_ready_q   <= io_ready_d;
         busy_q       <= busy_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.io_out    = io_out_q;
   assign bus.io_oeb    = io_oeb_q;
   assign bus.io_ready  = io_ready_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_io_out_arbiter.sv
// Bench for io_out_arbiter: default build checked against a timer-based
// reference model, plus a HOLD_CYCLES=1/BOOT_DELAY=1 build.
module tb_io_out_arbiter;
   localparam int N = 2;
   localparam int H = 4;
   localparam int B = 16;

   logic clk;
   logic rst_l;
   logic rst_f_l;
   int   total;
   int   bad;

   io_out_arbiter_if #(.NREQ(N)) bus ();
   io_out_arbiter_if #(.NREQ(N)) bus_f ();

   io_out_arbiter #(.NREQ(N), .HOLD_CYCLES(H), .BOOT_DELAY(B)) dut (
      .clk(clk), .rst_l(rst_l), .bus(bus));
   io_out_arbiter #(.NREQ(N), .HOLD_CYCLES(1), .BOOT_DELAY(1)) dut_f (
      .clk(clk), .rst_l(rst_f_l), .bus(bus_f));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference: boot countdown, hold countdown, rotating priority pointer
   int         m_boot;
   int         m_hold;
   int         m_last;
   logic [7:0] m_out;
   logic [1:0] exp_ready;

   function automatic logic [1:0] m_pick(input logic [1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return 2'(1 << ((last + k) % N));
      end
      return 2'b00;
   endfunction

   assign exp_ready = (m_boot == 0 && m_hold == 0) ? m_pick(bus.req_valid, m_last) : 2'b00;

   always @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         m_boot <= B; m_hold <= 0; m_last <= N - 1; m_out <= 8'h00;
      end else if (m_boot > 0) begin
         m_boot <= m_boot - 1;
      end else if (m_hold > 0) begin
         m_hold <= m_hold - 1;
      end else if (exp_ready != 2'b00) begin
         m_out  <= exp_ready[1] ? bus.req_data[15:8] : bus.req_data[7:0];
         m_last <= exp_ready[1] ? 1 : 0;
         m_hold <= H;
      end
   end

   logic [19:0] obs_v;
   logic [19:0] exp_v;
   assign obs_v = {bus.req_ready, bus.io_out, bus.busy, bus.io_ready, bus.io_oeb};
   assign exp_v = {exp_ready, m_out, (m_hold != 0), (m_boot == 0),
                   (m_boot == 0) ? 8'h00 : 8'hFF};

   task automatic do_reset();
      bus.req_valid = 2'b00;
      rst_l = 1'b0;
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      repeat (B) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [16:0] e;
      rst_l = 1'b0;
      bus.req_valid = 2'b00;
      bus.req_data  = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus.io_out, bus.io_oeb, bus.io_ready, bus.busy, bus.req_ready} !== {8'h00, 8'hFF, 1'b0, 1'b0, 2'b00}) begin
         bad++;
         $display("FAIL reset_values: got out=%h oeb=%h rdy=%b busy=%b rr=%b", bus.io_out, bus.io_oeb, bus.io_ready, bus.busy, bus.req_ready);
      end
      @(negedge clk);
      rst_l = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         e = (c >= B) ? {1'b1, 8'h00, 8'h00} : {1'b0, 8'hFF, 8'h00};
         total++;
         if ({bus.io_ready, bus.io_oeb, bus.io_out} !== e) begin
            bad++;
            $display("FAIL boot_cycle_%0d: got rdy=%b oeb=%h out=%h want %h", c, bus.io_ready, bus.io_oeb, bus.io_out, e);
         end
      end
   endtask

   task automatic test_single();
      int g[$];
      int busy_n;
      busy_n = 0;
      @(posedge clk); #1;
      bus.req_data  = 16'h0099;
      bus.req_valid = 2'b01;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL single_model_c%0d: got %h want %h", c, obs_v, exp_v);
         end
         if (bus.req_ready == 2'b01) g.push_back(c);
         if (bus.busy && g.size() == 1) busy_n++;
         @(posedge clk); #1;
         if (g.size() >= 2) bus.req_valid = 2'b00;
      end
      total++;
      if (g.size() != 2) begin
         bad++;
         $display("FAIL single_grants: got %0d grants want 2", g.size());
      end else begin
         total++;
         if (g[1] - g[0] != H + 1) begin
            bad++;
            $display("FAIL single_spacing: got %0d want %0d", g[1] - g[0], H + 1);
         end
      end
      total++;
      if (busy_n != H) begin
         bad++;
         $display("FAIL single_busy_len: got %0d want %0d", busy_n, H);
      end
      total++;
      if (bus.io_out !== 8'h99) begin
         bad++;
         $display("FAIL single_io_out: got %h want 99", bus.io_out);
      end
   endtask

   task automatic test_alternate();
      logic [7:0] vals[$];
      int         at[$];
      logic [7:0] prev;
      logic [7:0] want;
      do_reset();
      @(posedge clk); #1;
      bus.req_data  = 16'h2211;
      bus.req_valid = 2'b11;
      prev = bus.io_out;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL alt_model_c%0d: got %h want %h", c, obs_v, exp_v);
         end
         if (bus.io_out !== prev) begin
            vals.push_back(bus.io_out);
            at.push_back(c);
            prev = bus.io_out;
         end
      end
      bus.req_valid = 2'b00;
      total++;
      if (vals.size() < 4) begin
         bad++;
         $display("FAIL alt_count: got %0d changes want 4", vals.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 8'h11 : 8'h22;
            total++;
            if (vals[i] !== want) begin
               bad++;
               $display("FAIL alt_value_%0d: got %h want %h", i, vals[i], want);
            end
            if (i > 0) begin
               total++;
               if (at[i] - at[i-1] != H + 1) begin
                  bad++;
                  $display("FAIL alt_hold_%0d: got %0d want %0d", i, at[i] - at[i-1], H + 1);
               end
            end
         end
      end
   endtask

   task automatic test_stream();
      logic [7:0] nxt;
      logic [7:0] sent;
      int         last_c;
      int         got;
      logic       xfer;
      nxt = 8'h00; last_c = -1; got = 0; xfer = 1'b0; sent = 8'h00;
      @(posedge clk); #1;
      bus.req_data  = 16'h0000;
      bus.req_valid = 2'b01;
      for (int c = 0; c < 80 && got < 9; c++) begin
         @(negedge clk);
         if (xfer) begin
            total++;
            if (bus.io_out !== sent) begin
               bad++;
               $display("FAIL stream_value: got %h want %h", bus.io_out, sent);
            end
         end
         xfer = (bus.req_ready == 2'b01);
         if (xfer) begin
            if (last_c >= 0) begin
               total++;
               if (c - last_c > H + 1) begin
                  bad++;
                  $display("FAIL stream_gap: got %0d want <=%0d", c - last_c, H + 1);
               end
            end
            last_c = c;
            sent = nxt;
            got++;
         end
         @(posedge clk); #1;
         if (xfer) begin
            nxt = nxt + 8'd1;
            bus.req_data[7:0] = nxt;
            if (got >= 9) bus.req_valid = 2'b00;
         end
      end
      @(negedge clk);
      total++;
      if (got != 9 || bus.io_out !== 8'h08) begin
         bad++;
         $display("FAIL stream_done: got %0d bytes last=%h want 9 bytes last=08", got, bus.io_out);
      end
   endtask

   task automatic test_random();
      logic [1:0]  v;
      logic [15:0] d;
      logic [1:0]  gr;
      int          wait_n[2];
      v = 2'b00; d = 16'h0000; wait_n[0] = 0; wait_n[1] = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL rand_model_c%0d: got %h want %h", c, obs_v, exp_v);
         end
         gr = exp_ready;
         if (gr != 2'b00) begin
            for (int i = 0; i < 2; i++) begin
               if (gr[i]) begin
                  total++;
                  if (wait_n[i] > N - 1) begin
                     bad++;
                     $display("FAIL rand_fair_r%0d: got %0d waits want <=%0d", i, wait_n[i], N - 1);
                  end
                  wait_n[i] = 0;
               end else if (v[i]) begin
                  wait_n[i]++;
               end
            end
         end
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (v[i] && gr[i]) begin
               v[i] = 1'($urandom_range(0, 1));
               d[8*i +: 8] = 8'($urandom);
            end else if (!v[i]) begin
               wait_n[i] = 0;
               if ($urandom_range(0, 2) == 0) begin
                  v[i] = 1'b1;
                  d[8*i +: 8] = 8'($urandom);
               end
            end else if ($urandom_range(0, 19) == 0) begin
               v[i] = 1'b0;
               wait_n[i] = 0;
            end
         end
         bus.req_valid = v;
         bus.req_data  = d;
      end
      bus.req_valid = 2'b00;
   endtask

   task automatic test_reset_mid_hold();
      int         n;
      logic [1:0] er;
      logic [7:0] eo;
      n = 0;
      bus.req_valid = 2'b00;
      while (!(m_boot == 0 && m_hold == 0) && n < 40) begin
         @(negedge clk); n++;
      end
      @(posedge clk); #1;
      bus.req_data  = 16'h5A00;
      bus.req_valid = 2'b10;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (bus.req_ready !== 2'b10 && n < 12);
      total++;
      if (bus.req_ready !== 2'b10) begin
         bad++;
         $display("FAIL midhold_grant: got %b want 10", bus.req_ready);
      end
      @(posedge clk); #1;
      bus.req_data = 16'h7700;
      total++;
      if (bus.busy !== 1'b1 || bus.io_out !== 8'h5A) begin
         bad++;
         $display("FAIL midhold_enter: got busy=%b out=%h want 1 5A", bus.busy, bus.io_out);
      end
      @(posedge clk); #2;
      rst_l = 1'b0;
      #1;
      total++;
      if ({bus.io_out, bus.io_oeb, bus.io_ready, bus.busy, bus.req_ready} !== {8'h00, 8'hFF, 1'b0, 1'b0, 2'b00}) begin
         bad++;
         $display("FAIL midhold_async: got out=%h oeb=%h rdy=%b busy=%b rr=%b", bus.io_out, bus.io_oeb, bus.io_ready, bus.busy, bus.req_ready);
      end
      @(negedge clk);
      rst_l = 1'b1;
      for (int c = 1; c <= B + 1; c++) begin
         @(negedge clk);
         er = (c == B) ? 2'b10 : 2'b00;
         eo = (c == B + 1) ? 8'h77 : 8'h00;
         total++;
         if (bus.req_ready !== er || bus.io_out !== eo || bus.io_ready !== (c >= B)) begin
            bad++;
            $display("FAIL midhold_reboot_c%0d: got rr=%b out=%h rdy=%b want %b %h %b", c, bus.req_ready, bus.io_out, bus.io_ready, er, eo, (c >= B));
         end
      end
      bus.req_valid = 2'b00;
   endtask

   task automatic test_fast_build();
      logic [1:0] er;
      logic [7:0] eo;
      bus_f.req_valid = 2'b00;
      bus_f.req_data  = 16'h2211;
      @(negedge clk);
      rst_f_l = 1'b1;
      #1;
      total++;
      if (bus_f.io_ready !== 1'b0) begin
         bad++;
         $display("FAIL fast_boot_pre: got %b want 0", bus_f.io_ready);
      end
      @(negedge clk);
      total++;
      if (bus_f.io_ready !== 1'b1 || bus_f.io_oeb !== 8'h00) begin
         bad++;
         $display("FAIL fast_boot: got rdy=%b oeb=%h want 1 00", bus_f.io_ready, bus_f.io_oeb);
      end
      @(posedge clk); #1;
      bus_f.req_valid = 2'b11;
      for (int c = 2; c <= 11; c++) begin
         @(negedge clk);
         er = (c % 2 == 0) ? (((c / 2) % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
         total++;
         if (bus_f.req_ready !== er) begin
            bad++;
            $display("FAIL fast_grant_c%0d: got %b want %b", c, bus_f.req_ready, er);
         end
         if (c % 2 == 1) begin
            eo = (((c - 1) / 2) % 2 == 1) ? 8'h11 : 8'h22;
            total++;
            if (bus_f.io_out !== eo || bus_f.busy !== 1'b1) begin
               bad++;
               $display("FAIL fast_out_c%0d: got out=%h busy=%b want %h 1", c, bus_f.io_out, bus_f.busy, eo);
            end
         end
      end
      bus_f.req_valid = 2'b00;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_f_l = 1'b0;
      bus_f.req_valid = 2'b00;
      bus_f.req_data  = 16'h0000;
      test_reset();
      test_single();
      test_alternate();
      test_stream();
      test_random();
      test_reset_mid_hold();
      test_fast_build();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
